// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for ram_port_arbiter: FSM state encoding and width helpers.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Channel-index width; a single channel still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter running 0 .. cycles-1.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; search starts at ptr+1 and wraps.
module rr_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int IDX_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_any
);

  int best_rank;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    best_rank = NUM_CH;
    // Rank 0 is the channel right after ptr; lowest-ranked requester wins.
    for (int i = 0; i < NUM_CH; i++) begin
      if (req[i] && (((i + NUM_CH - 1 - int'(ptr)) % NUM_CH) < best_rank)) begin
        best_rank = (i + NUM_CH - 1 - int'(ptr)) % NUM_CH;
        grant_idx = IDX_W'(i);
        grant_any = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      grant[i] = grant_any && (grant_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin front end for RAM port b, one access in flight at a time.
// Define RAM_ARB_REG_OUT_EN to register ram_dout once before capture (read latency +1).
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int RAM_WIDTH   = 128,
  parameter int NUM_CH      = 3,
  parameter int RAM_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH-1:0]            req_we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CH*RAM_WIDTH-1:0]  req_wdata,
  output logic [NUM_CH-1:0]            resp_valid,
  output logic [RAM_WIDTH-1:0]         resp_rdata,
  output logic [ADDR_WIDTH-1:0]        ram_addr,
  output logic [RAM_WIDTH-1:0]         ram_din,
  output logic                         ram_we,
  input  logic [RAM_WIDTH-1:0]         ram_dout
);

  localparam int IDX_W = idx_width(NUM_CH);
`ifdef RAM_ARB_REG_OUT_EN
  localparam int LAT_CYC = RAM_LATENCY + 1;
`else
  localparam int LAT_CYC = RAM_LATENCY;
`endif
  localparam int               CNT_W    = cnt_width(LAT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT_CYC - 1);

  arb_state_t            state;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      ch_q;
  logic                  we_q;
  logic                  ram_we_q;
  logic [CNT_W-1:0]      cnt;
  logic [NUM_CH-1:0]     win_grant;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_any;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [RAM_WIDTH-1:0]  win_wdata;
  logic [NUM_CH-1:0]     ch_onehot;
  logic [RAM_WIDTH-1:0]  cap_data;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .grant_any (win_any)
  );

  assign req_ready = (state == ST_IDLE && rdy) ? win_grant : '0;
  assign ram_we    = ram_we_q & rdy;
  assign ch_onehot = (NUM_CH)'(1) << ch_q;

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_grant[i]) begin
        win_we    = req_we[i];
        win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_wdata = req_wdata[i*RAM_WIDTH +: RAM_WIDTH];
      end
    end
  end

`ifdef RAM_ARB_REG_OUT_EN
  logic [RAM_WIDTH-1:0] dout_q;

  // The RAM runs regardless of rdy, so this stage tracks it every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_q <= '0;
    else     dout_q <= ram_dout;
  end
  assign cap_data = dout_q;
`else
  assign cap_data = ram_dout;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= IDX_W'(NUM_CH - 1);
      ch_q       <= '0;
      we_q       <= 1'b0;
      ram_we_q   <= 1'b0;
      cnt        <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      ram_addr   <= '0;
      ram_din    <= '0;
    end else if (rdy) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            ch_q     <= win_idx;
            ptr      <= win_idx;
            we_q     <= win_we;
            ram_we_q <= win_we;
            ram_addr <= win_addr;
            ram_din  <= win_wdata;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ram_we_q <= 1'b0;
          if (we_q) begin
            resp_valid <= ch_onehot;
            resp_rdata <= '0;
            state      <= ST_RESP;
          end else begin
            cnt   <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == CNT_LAST) begin
            resp_valid <= ch_onehot;
            resp_rdata <= cap_data;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          resp_valid <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
